// File: rtl/bfly_port_fifo.sv
// Elastic output buffer for one port of a butterfly 2x2 crossbar stage.
// First-word fall-through FIFO that also exposes the next stage's routing bit.
module bfly_port_fifo #(
  parameter int DW      = 35,
  parameter int DEPTH   = 4,
  parameter int DIR_BIT = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [DW-1:0]            i_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DW-1:0]            o_data,
  output logic                     o_dir,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Full/empty come from the occupancy register, never from pointer compare.
  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign i_ready = !o_full;
  assign o_valid = !o_empty;
  assign o_count = count;

  assign push = i_valid && i_ready;
  assign pop  = o_valid && o_ready;

  // NOTE: storage has no reset; only pointers/count are cleared, and the
  // output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_data = o_empty ? '0 : mem[rd_ptr];
  assign o_dir  = o_data[DIR_BIT];

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(o_full && o_empty));

endmodule

// File: tb/tb_bfly_port_fifo.sv
// Self-checking bench for bfly_port_fifo: directed vector table plus a
// queue scoreboard for streaming, random traffic and mid-stream reset.
module tb_bfly_port_fifo;

  localparam int DW      = 35;
  localparam int DEPTH   = 4;
  localparam int DIR_BIT = 34;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_dir;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  bfly_port_fifo #(.DW(DW), .DEPTH(DEPTH), .DIR_BIT(DIR_BIT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_dir   (o_dir),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_dir;
    logic [CW-1:0] e_count;
    logic          e_full;
    logic          e_iready;
  } vec_t;

  localparam logic [DW-1:0] DAA = 35'h4_0000_00AA;
  localparam logic [DW-1:0] D1  = 35'h4_0000_0001;
  localparam logic [DW-1:0] D2  = 35'h0_0000_0002;
  localparam logic [DW-1:0] D3  = 35'h4_0000_0003;
  localparam logic [DW-1:0] D4  = 35'h2_0000_0004;
  localparam logic [DW-1:0] D5  = 35'h6_0000_0005;
  localparam logic [DW-1:0] D55 = 35'h1_0000_0055;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            popped   = 0;
  logic [DW-1:0] q[$];
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  vec_t          vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of traffic checked against the queue model; returns whether a push happened.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy, output bit pushed);
    logic [DW-1:0] head;
    bit            do_pop;
    @(negedge clk);
    i_valid = iv;
    i_data  = d;
    o_ready = ordy;
    #1;
    head = (q.size() != 0) ? q[0] : '0;
    check("sb_valid",  64'(o_valid), 64'(q.size() != 0));
    check("sb_data",   64'(o_data),  64'(head));
    check("sb_dir",    64'(o_dir),   64'(head[DIR_BIT]));
    check("sb_count",  64'(o_count), 64'(q.size()));
    check("sb_iready", 64'(i_ready), 64'(q.size() < DEPTH));
    check("sb_full",   64'(o_full),  64'(q.size() == DEPTH));
    check("sb_empty",  64'(o_empty), 64'(q.size() == 0));
    if (hold_prev) check("stable_data", 64'(o_data), 64'(prev_data));
    hold_prev = (q.size() != 0) && !ordy;
    prev_data = head;
    do_pop = (q.size() != 0) && ordy;
    pushed = iv && (q.size() < DEPTH);
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      popped++;
    end
    if (pushed) q.push_back(d);
  endtask

  initial begin
    bit            pushed;
    int            n_pushed;
    int            cyc;
    logic [DW-1:0] rd;

    vecs[0]  = '{1'b1, DAA, 1'b1, 1'b0, '0,  1'b0, 3'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, '0,  1'b1, 1'b1, DAA, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, '0,  1'b0, 1'b0, '0,  1'b0, 3'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, D1,  1'b0, 1'b0, '0,  1'b0, 3'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, D2,  1'b0, 1'b1, D1,  1'b1, 3'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, D3,  1'b0, 1'b1, D1,  1'b1, 3'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, D4,  1'b0, 1'b1, D1,  1'b1, 3'd3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, D5,  1'b0, 1'b1, D1,  1'b1, 3'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, D5,  1'b0, 1'b1, D1,  1'b1, 3'd4, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, D5,  1'b1, 1'b1, D1,  1'b1, 3'd4, 1'b1, 1'b0};
    vecs[10] = '{1'b1, D5,  1'b1, 1'b1, D2,  1'b0, 3'd3, 1'b0, 1'b1};
    vecs[11] = '{1'b0, '0,  1'b1, 1'b1, D3,  1'b1, 3'd3, 1'b0, 1'b1};
    vecs[12] = '{1'b0, '0,  1'b1, 1'b1, D4,  1'b0, 3'd2, 1'b0, 1'b1};
    vecs[13] = '{1'b0, '0,  1'b1, 1'b1, D5,  1'b1, 3'd1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, '0,  1'b0, 1'b0, '0,  1'b0, 3'd0, 1'b0, 1'b1};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid",  64'(o_valid), 64'd0);
    check("rst_count",  64'(o_count), 64'd0);
    check("rst_empty",  64'(o_empty), 64'd1);
    check("rst_full",   64'(o_full),  64'd0);
    check("rst_iready", 64'(i_ready), 64'd1);
    check("rst_data",   64'(o_data),  64'd0);
    check("rst_dir",    64'(o_dir),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: outputs checked before the edge that applies each row's inputs.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      i_valid = vecs[i].iv;
      i_data  = vecs[i].d;
      o_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_valid", i),  64'(o_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i),   64'(o_data),  64'(vecs[i].e_data));
      check($sformatf("vec%0d_dir", i),    64'(o_dir),   64'(vecs[i].e_dir));
      check($sformatf("vec%0d_count", i),  64'(o_count), 64'(vecs[i].e_count));
      check($sformatf("vec%0d_full", i),   64'(o_full),  64'(vecs[i].e_full));
      check($sformatf("vec%0d_empty", i),  64'(o_empty), 64'(!vecs[i].e_valid));
      check($sformatf("vec%0d_iready", i), 64'(i_ready), 64'(vecs[i].e_iready));
      @(posedge clk);
    end

    // Streaming at full rate: 20 flits, occupancy pinned at 1.
    for (int k = 0; k < 20; k++) begin
      rd = {3'(k % 8), 32'(32'hC000_0000 + k)};
      cycle(1'b1, rd, 1'b1, pushed);
      check("stream_push", 64'(pushed), 64'd1);
      if (k >= 1) check("stream_count", 64'(o_count), 64'd1);
    end
    cycle(1'b0, '0, 1'b1, pushed);
    cycle(1'b0, '0, 1'b1, pushed);
    check("stream_popped", 64'(popped), 64'd20);

    // Random valid/ready traffic against the scoreboard.
    popped   = 0;
    n_pushed = 0;
    cyc      = 0;
    while (n_pushed < 1000 && cyc < 20000) begin
      rd = {3'($urandom_range(7, 0)), 32'($urandom)};
      cycle(1'($urandom_range(1, 0)), rd, 1'($urandom_range(1, 0)), pushed);
      if (pushed) n_pushed++;
      cyc++;
    end
    check("rand_pushed", 64'(n_pushed), 64'd1000);
    for (int i = 0; i < 50 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1, pushed);
    cycle(1'b0, '0, 1'b0, pushed);
    check("rand_popped", 64'(popped), 64'd1000);

    // Asynchronous reset with three flits buffered.
    for (int k = 0; k < 3; k++) cycle(1'b1, {3'd4, 32'(k + 1)}, 1'b0, pushed);
    cycle(1'b0, '0, 1'b0, pushed);
    check("pre_rst_count", 64'(o_count), 64'd3);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_valid",  64'(o_valid), 64'd0);
    check("mid_rst_count",  64'(o_count), 64'd0);
    check("mid_rst_iready", 64'(i_ready), 64'd1);
    check("mid_rst_data",   64'(o_data),  64'd0);
    q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, D55, 1'b0, pushed);
    cycle(1'b0, '0, 1'b1, pushed);
    check("post_rst_data", 64'(o_data), 64'(D55));
    check("post_rst_dir",  64'(o_dir),  64'd0);
    cycle(1'b0, '0, 1'b0, pushed);
    check("post_rst_empty", 64'(o_empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
